// File: rtl/dec_unit.sv
// Loadable down-counting decrementer with valid/ready load and a one-cycle done pulse.
// Optional feature: define AUTO_RELOAD_EN to reload the last start value at terminal count.
module dec_unit #(
   parameter int DATAWIDTH = 8
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [DATAWIDTH-1:0] a,
   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic                 en,
   input  logic                 abort,
   output logic [DATAWIDTH-1:0] d,
   output logic                 zero,
   output logic                 done
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [DATAWIDTH-1:0] ONE = DATAWIDTH'(1);

   state_t               state, state_nxt;
   logic [DATAWIDTH-1:0] d_nxt;
   logic                 done_nxt;

`ifdef AUTO_RELOAD_EN
   logic [DATAWIDTH-1:0] reload, reload_nxt;
`endif

   // NOTE: state is updated with non-blocking assignments so every register samples
   // the same pre-edge values regardless of statement order.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state  <= IDLE;
         d      <= '0;
         done   <= 1'b0;
`ifdef AUTO_RELOAD_EN
         reload <= '0;
`endif
      end else begin
         state  <= state_nxt;
         d      <= d_nxt;
         done   <= done_nxt;
`ifdef AUTO_RELOAD_EN
         reload <= reload_nxt;
`endif
      end
   end

   // NOTE: every signal gets a default before the branches, so no path leaves a
   // value unassigned and no latch is inferred.
   always_comb begin
      state_nxt  = state;
      d_nxt      = d;
      done_nxt   = 1'b0;
`ifdef AUTO_RELOAD_EN
      reload_nxt = reload;
`endif
      if (abort) begin
         // abort wins over load and over the terminal step, so it never pulses done
         state_nxt = IDLE;
         d_nxt     = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (a_valid) begin
`ifdef AUTO_RELOAD_EN
                  reload_nxt = a;
`endif
                  if (a != '0) begin
                     d_nxt     = a;
                     state_nxt = RUN;
                  end else begin
                     d_nxt    = '0;
                     done_nxt = 1'b1;
                  end
               end
            end
            RUN: begin
               if (en) begin
                  // terminal detection at 1 (or below) keeps the count from wrapping
                  if (d <= ONE) begin
                     done_nxt = 1'b1;
`ifdef AUTO_RELOAD_EN
                     d_nxt     = reload;
                     state_nxt = RUN;
`else
                     d_nxt     = '0;
                     state_nxt = IDLE;
`endif
                  end else begin
                     d_nxt = d - ONE;
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
               d_nxt     = '0;
            end
         endcase
      end
   end

   always_comb begin
      a_ready = (state == IDLE) && !Rst;
      zero    = (d == '0);
   end

endmodule
